// File: rtl/map_sweep_scheduler_if.sv
// Map BRAM read port plus tile-blitter start/busy/done handshake.
// The scheduler drives the master side; BRAM and blitter sit on the slave side.
interface map_sweep_scheduler_if;
  logic [18:0] map_addr;
  logic [15:0] map_data;
  logic        blit_start;
  logic [18:0] blit_tile_id;
  logic [3:0]  blit_grid_x;
  logic [3:0]  blit_grid_y;
  logic        blit_busy;
  logic        blit_done;

  modport master (
    output map_addr, blit_start, blit_tile_id, blit_grid_x, blit_grid_y,
    input  map_data, blit_busy, blit_done
  );

  modport slave (
    input  map_addr, blit_start, blit_tile_id, blit_grid_x, blit_grid_y,
    output map_data, blit_busy, blit_done
  );
endinterface

// File: rtl/map_sweep_scheduler.sv
// Walks the tile grid in raster order, fetches each tile id from map BRAM, swaps in the
// hero tile at the player cell and hands every tile to the blitter.
module map_sweep_scheduler #(
  parameter int          MAP_WIDTH  = 13,
  parameter int          MAP_HEIGHT = 13,
  parameter logic [18:0] HERO_TILE  = 19'd16
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         redraw_req,
  input  logic [18:0]                  map_id,
  input  logic [3:0]                   player_x,
  input  logic [3:0]                   player_y,
  map_sweep_scheduler_if.master        bif,
  output logic                         busy,
  output logic                         frame_done
);

  typedef enum logic [2:0] {IDLE, FETCH, LATCH, ISSUE, WAIT, DONE} state_t;

  state_t      state_q;
  logic [3:0]  x_q, y_q;
  logic [3:0]  x_d, y_d;
  logic        last_cell;
  logic [18:0] snap_id_q;
  logic [3:0]  snap_px_q, snap_py_q;
  logic        pending_q;
  logic [18:0] addr_q;
  logic [18:0] tile_q;
  logic [3:0]  gx_q, gy_q;
  logic        busy_q;
  logic        fdone_q;

  // 19-bit arithmetic throughout, so large map ids wrap naturally.
  function automatic logic [18:0] cell_addr(input logic [18:0] id,
                                            input logic [3:0]  cx,
                                            input logic [3:0]  cy);
    return id * 19'(MAP_WIDTH * MAP_HEIGHT) + 19'(cy) * 19'(MAP_WIDTH) + 19'(cx);
  endfunction

  always_comb begin
    last_cell = (x_q == 4'(MAP_WIDTH - 1)) && (y_q == 4'(MAP_HEIGHT - 1));
    x_d = x_q + 4'd1;
    y_d = y_q;
    if (x_q == 4'(MAP_WIDTH - 1)) begin
      x_d = 4'd0;
      y_d = y_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      x_q       <= 4'd0;
      y_q       <= 4'd0;
      snap_id_q <= 19'd0;
      snap_px_q <= 4'd0;
      snap_py_q <= 4'd0;
      pending_q <= 1'b0;
      addr_q    <= 19'd0;
      tile_q    <= 19'd0;
      gx_q      <= 4'd0;
      gy_q      <= 4'd0;
      busy_q    <= 1'b0;
      fdone_q   <= 1'b0;
    end else begin
      fdone_q <= 1'b0;
      if (redraw_req && state_q != IDLE) pending_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (redraw_req || pending_q) begin
            // Snapshot so mid-sweep game-state changes never tear a frame.
            snap_id_q <= map_id;
            snap_px_q <= player_x;
            snap_py_q <= player_y;
            x_q       <= 4'd0;
            y_q       <= 4'd0;
            addr_q    <= cell_addr(map_id, 4'd0, 4'd0);
            pending_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= FETCH;
          end
        end
        FETCH: state_q <= LATCH;
        LATCH: begin
          tile_q  <= (x_q == snap_px_q && y_q == snap_py_q) ? HERO_TILE
                                                            : {3'b000, bif.map_data};
          gx_q    <= x_q;
          gy_q    <= y_q;
          state_q <= ISSUE;
        end
        ISSUE: if (!bif.blit_busy) state_q <= WAIT;
        WAIT: begin
          if (bif.blit_done) begin
            if (last_cell) begin
              fdone_q <= 1'b1;
              state_q <= DONE;
            end else begin
              x_q     <= x_d;
              y_q     <= y_d;
              addr_q  <= cell_addr(snap_id_q, x_d, y_d);
              state_q <= FETCH;
            end
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Start is decoded from state so it fires in the very first cycle the blitter frees up.
  assign bif.blit_start   = (state_q == ISSUE) && !bif.blit_busy;
  assign bif.map_addr     = addr_q;
  assign bif.blit_tile_id = tile_q;
  assign bif.blit_grid_x  = gx_q;
  assign bif.blit_grid_y  = gy_q;
  assign busy             = busy_q;
  assign frame_done       = fdone_q;

endmodule
